// File: rtl/hazard_scheduler_if.sv
// Hazard-control bundle between the RV32I datapath (master) and hazard_scheduler (slave).
// HAZARD_PERF_EN adds the three performance-counter outputs.
interface hazard_scheduler_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic       RegWriteM;
    logic       RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE;
    logic       MulStartE;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       FlushD;
    logic       FlushE;
    logic       FlushM;
    logic       MulBusy;
    logic       MulDoneE;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCount;
    logic [31:0] FlushCount;
    logic [31:0] MulOpCount;
`endif

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, MulBusy, MulDoneE
`ifdef HAZARD_PERF_EN
        , input StallCount, FlushCount, MulOpCount
`endif
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, MulBusy, MulDoneE
`ifdef HAZARD_PERF_EN
        , output StallCount, FlushCount, MulOpCount
`endif
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Forwarding, stall/flush and multi-cycle execute sequencing for the 5-stage RV32I pipeline.
// Latency: forwarding/stall/flush are combinational; a multi-cycle op holds E for MUL_LATENCY cycles.
// Backpressure: StallF/StallD/StallE freeze upstream stages; FlushM injects a bubble behind a held op.
// Optional HAZARD_PERF_EN adds free-running stall/flush/mul-op counters.
module hazard_scheduler #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scheduler_if.slave  hz
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit               MULTI    = (MUL_LATENCY > 1);
    localparam int               LOAD_I   = MULTI ? (MUL_LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = LOAD_I[CNT_W-1:0];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_hold, mul_done;
    logic             lw_stall;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall_fd, flush_d, flush_e;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wm,
        input logic [4:0] rdm,
        input logic       ww,
        input logic [4:0] rdw
    );
        if (wm && (rdm != 5'd0) && (rdm == rs)) begin
            return 2'b10;
        end else if (ww && (rdw != 5'd0) && (rdw == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    assign fwd_b = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

    assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // MulStartE stays high while the same op sits in E, so BUSY ignores it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_hold = 1'b0;
        mul_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.MulStartE) begin
                    if (MULTI) begin
                        mul_hold = 1'b1;
                        cnt_d    = CNT_LOAD;
                        state_d  = BUSY;
                    end else begin
                        mul_done = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mul_hold = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    mul_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_fd = lw_stall | mul_hold;
    assign flush_d  = hz.PCSrcE & ~mul_hold;
    assign flush_e  = (lw_stall | hz.PCSrcE) & ~mul_hold;

    // Everything is forced low during reset, including the combinational forwarding paths.
    assign hz.ForwardAE = reset ? 2'b00 : fwd_a;
    assign hz.ForwardBE = reset ? 2'b00 : fwd_b;
    assign hz.StallF    = stall_fd & ~reset;
    assign hz.StallD    = stall_fd & ~reset;
    assign hz.StallE    = mul_hold & ~reset;
    assign hz.FlushD    = flush_d & ~reset;
    assign hz.FlushE    = flush_e & ~reset;
    assign hz.FlushM    = mul_hold & ~reset;
    assign hz.MulBusy   = (state_q == BUSY) & ~reset;
    assign hz.MulDoneE  = mul_done & ~reset;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, mul_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mul_cnt_q   <= '0;
        end else begin
            if (stall_fd)            stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_d | flush_e)   flush_cnt_q <= flush_cnt_q + 32'd1;
            if (mul_done)            mul_cnt_q   <= mul_cnt_q + 32'd1;
        end
    end

    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;
    assign hz.MulOpCount = mul_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed vector table, hand-written multi-cycle/reset sequences,
// then randomized stimulus against a cycle-age reference model.
module tb_hazard_scheduler;
    localparam int L = 4;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       regwm, regww;
        logic [1:0] rsrc;
        logic       pcsrc, mulstart;
    } in_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic sf, sd, se, fd, fe, fm, busy, done;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  o;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_scheduler_if hz ();

    hazard_scheduler #(.MUL_LATENCY(L), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: age of the op in E (-1 = none) plus event counters.
    int          m_el = -1;
    logic [31:0] m_stall = '0, m_flush = '0, m_mul = '0;

    function automatic in_t mk_in(
        input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
        input logic regwm, regww, input logic [1:0] rsrc, input logic pcsrc, mulstart);
        in_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw;
        v.regwm = regwm; v.regww = regww; v.rsrc = rsrc;
        v.pcsrc = pcsrc; v.mulstart = mulstart;
        return v;
    endfunction

    function automatic out_t mk(input logic [1:0] fa, fb,
                                input logic sf, sd, se, fd, fe, fm, busy, done);
        out_t o;
        o.fa = fa; o.fb = fb; o.sf = sf; o.sd = sd; o.se = se;
        o.fd = fd; o.fe = fe; o.fm = fm; o.busy = busy; o.done = done;
        return o;
    endfunction

    function automatic logic [1:0] ref_fwd(input in_t v, input logic [4:0] rs);
        if (v.regwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
        if (v.regww && v.rdw != 0 && v.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t model_eval(input in_t v, input logic rst);
        out_t o;
        logic lw, active, hold, done;
        int   age;
        o = '0;
        if (rst) return o;
        lw     = (v.rsrc == 2'b01) && (v.rde != 0) && (v.rde == v.rs1d || v.rde == v.rs2d);
        active = (m_el >= 0) || v.mulstart;
        age    = (m_el < 0) ? 0 : m_el;
        hold   = active && (age < L - 1);
        done   = active && (age == L - 1);
        o.fa   = ref_fwd(v, v.rs1e);
        o.fb   = ref_fwd(v, v.rs2e);
        o.sf   = lw | hold;
        o.sd   = lw | hold;
        o.se   = hold;
        o.fm   = hold;
        o.fd   = v.pcsrc & ~hold;
        o.fe   = (lw | v.pcsrc) & ~hold;
        o.busy = (m_el >= 0);
        o.done = done;
        return o;
    endfunction

    task automatic model_advance(input in_t v, input logic rst, input out_t m);
        if (rst) begin
            m_el = -1; m_stall = '0; m_flush = '0; m_mul = '0;
        end else begin
            if (m.done) m_el = -1;
            else if (m_el >= 0 || v.mulstart) m_el = ((m_el < 0) ? 0 : m_el) + 1;
            if (m.sf) m_stall = m_stall + 32'd1;
            if (m.fd | m.fe) m_flush = m_flush + 32'd1;
            if (m.done) m_mul = m_mul + 32'd1;
        end
    endtask

    task automatic drive(input in_t v);
        hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
        hz.RdE = v.rde; hz.RdM = v.rdm; hz.RdW = v.rdw;
        hz.RegWriteM = v.regwm; hz.RegWriteW = v.regww; hz.ResultSrcE = v.rsrc;
        hz.PCSrcE = v.pcsrc; hz.MulStartE = v.mulstart;
    endtask

    function automatic out_t sample();
        return mk(hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE,
                  hz.FlushD, hz.FlushE, hz.FlushM, hz.MulBusy, hz.MulDoneE);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive after the edge, compare at the falling edge, then step the model.
    task automatic step(input in_t v, input logic rst, input out_t exp,
                        input bit use_model, input string name);
        out_t m;
        @(posedge clk); #1;
        drive(v);
        reset = rst;
        @(negedge clk);
        m = model_eval(v, rst);
        check(name, 32'(sample()), use_model ? 32'(m) : 32'(exp));
`ifdef HAZARD_PERF_EN
        check({name, "_stallcnt"}, hz.StallCount, m_stall);
        check({name, "_flushcnt"}, hz.FlushCount, m_flush);
        check({name, "_mulcnt"},   hz.MulOpCount, m_mul);
`endif
        model_advance(v, rst, m);
    endtask

    vec_t vecs[12];
    in_t  z, fwd5, ms;

    initial begin
        z    = '0;
        fwd5 = mk_in(0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, 0);
        ms   = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);

        vecs[0]  = '{mk_in(0,0,5,0,0,5,5,1,1,2'b00,0,0), mk(2'b10,2'b00,0,0,0,0,0,0,0,0), "fwd_m_prio"};
        vecs[1]  = '{mk_in(0,0,5,0,0,5,5,0,1,2'b00,0,0), mk(2'b01,2'b00,0,0,0,0,0,0,0,0), "fwd_w"};
        vecs[2]  = '{mk_in(0,0,0,0,0,0,0,1,1,2'b00,0,0), mk(2'b00,2'b00,0,0,0,0,0,0,0,0), "x0_guard"};
        vecs[3]  = '{mk_in(0,0,9,3,0,3,9,1,1,2'b00,0,0), mk(2'b01,2'b10,0,0,0,0,0,0,0,0), "fwd_mixed"};
        vecs[4]  = '{mk_in(0,0,6,6,0,6,0,1,0,2'b00,0,0), mk(2'b10,2'b10,0,0,0,0,0,0,0,0), "fwd_both_m"};
        vecs[5]  = '{mk_in(0,7,0,0,7,0,0,0,0,2'b01,0,0), mk(2'b00,2'b00,1,1,0,0,1,0,0,0), "load_use_rs2"};
        vecs[6]  = '{mk_in(0,0,0,0,0,0,0,0,0,2'b01,0,0), mk(2'b00,2'b00,0,0,0,0,0,0,0,0), "load_use_rd0"};
        vecs[7]  = '{mk_in(7,0,0,0,7,0,0,0,0,2'b10,0,0), mk(2'b00,2'b00,0,0,0,0,0,0,0,0), "not_load"};
        vecs[8]  = '{mk_in(4,1,0,0,4,0,0,0,0,2'b01,0,0), mk(2'b00,2'b00,1,1,0,0,1,0,0,0), "load_use_rs1"};
        vecs[9]  = '{mk_in(0,0,0,0,0,0,0,0,0,2'b00,1,0), mk(2'b00,2'b00,0,0,0,1,1,0,0,0), "branch"};
        vecs[10] = '{mk_in(0,7,0,0,7,0,0,0,0,2'b01,1,0), mk(2'b00,2'b00,1,1,0,1,1,0,0,0), "load_branch"};
        vecs[11] = '{mk_in(0,0,0,8,0,0,8,0,0,2'b00,0,0), mk(2'b00,2'b00,0,0,0,0,0,0,0,0), "w_no_write"};

        drive(z);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Reset gates even live forwarding matches.
        step(fwd5, 1'b1, '0, 1'b0, "reset_state");
        step(z,    1'b0, '0, 1'b0, "idle_after_reset");

        foreach (vecs[k]) step(vecs[k].i, 1'b0, vecs[k].o, 1'b0, vecs[k].name);

        // Multi-cycle op with a branch arriving one cycle in: flush must not kill it.
        step(ms, 1'b0, mk(0,0,1,1,1,0,0,1,0,0), 1'b0, "mul_t0");
        step(mk_in(0,0,0,0,0,0,0,0,0,2'b00,1,1), 1'b0, mk(0,0,1,1,1,0,0,1,1,0), 1'b0, "mul_t1_branch");
        step(ms, 1'b0, mk(0,0,1,1,1,0,0,1,1,0), 1'b0, "mul_t2");
        step(ms, 1'b0, mk(0,0,0,0,0,0,0,0,1,1), 1'b0, "mul_t3_done");
        step(z,  1'b0, mk(0,0,0,0,0,0,0,0,0,0), 1'b0, "mul_t4_idle");

        // Reset one cycle into an op abandons it.
        step(ms,   1'b0, mk(0,0,1,1,1,0,0,1,0,0), 1'b0, "rst_op_t0");
        step(ms,   1'b1, '0, 1'b0, "rst_op_t1");
        step(fwd5, 1'b1, '0, 1'b0, "rst_op_held");
`ifdef HAZARD_PERF_EN
        check("rst_stallcnt_zero", hz.StallCount, 32'd0);
        check("rst_flushcnt_zero", hz.FlushCount, 32'd0);
        check("rst_mulcnt_zero",   hz.MulOpCount, 32'd0);
`endif
        step(fwd5, 1'b0, mk(2'b10,0,0,0,0,0,0,0,0,0), 1'b0, "post_rst_fwd");
        step(z,    1'b0, '0, 1'b0, "post_rst_idle");

        for (int n = 0; n < 800; n++) begin
            in_t r;
            logic rr;
            r.rs1d = 5'($urandom_range(0, 3));
            r.rs2d = 5'($urandom_range(0, 3));
            r.rs1e = 5'($urandom_range(0, 3));
            r.rs2e = 5'($urandom_range(0, 3));
            r.rde  = 5'($urandom_range(0, 3));
            r.rdm  = 5'($urandom_range(0, 3));
            r.rdw  = 5'($urandom_range(0, 3));
            r.regwm = 1'($urandom_range(0, 1));
            r.regww = 1'($urandom_range(0, 1));
            r.rsrc  = 2'($urandom_range(0, 3));
            r.pcsrc = ($urandom_range(0, 3) == 0);
            r.mulstart = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 49) == 0);
            step(r, rr, '0, 1'b1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
